hazard_ctrl: RTL and testbench
==============================

Name: hazard_ctrl

Overview:
Central stall/flush generator for the 5-stage pipeline, driving the stall and flush inputs of the IF/ID, ID/EX, EX/MEM and MEM/WB registers and the PC hold.
- Detects load-use hazards and branch/jump redirects resolved in MEM.
- Sequences multi-cycle instruction- and data-memory waits through a small FSM with a data-memory timeout.
- Discards stale fetches that return after a redirect.

Parameters:
DMEM_TIMEOUT, 64, consecutive data-memory wait cycles before bus_error; must be >=2.
TO_W, $clog2(DMEM_TIMEOUT+1), timeout counter width (derived; do not override).

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-high reset
id_rs1_addr  in  5  rs1 of instruction in ID
id_rs2_addr  in  5  rs2 of instruction in ID
id_uses_rs1  in  1  ID instruction reads rs1
id_uses_rs2  in  1  ID instruction reads rs2
ex_rd_addr  in  5  rd in EX (ID/EX output)
ex_MemRead  in  1  EX instruction is a load
mem_branch_taken  in  1  taken branch/jump in MEM (EX/MEM output)
mem_access  in  1  MEM instruction is a load or store
dmem_ready  in  1  data memory completes this cycle
imem_ready  in  1  fetched instruction valid this cycle
pc_stall  out  1  hold PC
pc_redirect  out  1  PC loads branch target this cycle
if_id_stall, if_id_flush  out  1 each  IF/ID controls
id_ex_stall, id_ex_flush  out  1 each  ID/EX controls
ex_mem_stall, ex_mem_flush  out  1 each  EX/MEM controls
mem_wb_stall, mem_wb_flush  out  1 each  MEM/WB controls
bus_error  out  1  sticky data-memory timeout
stall_cycles  out  32  perf counter (see Optional Feature)
flush_events  out  32  perf counter (see Optional Feature)

Behaviour:
- One clock (clk). Reset is synchronous and active-high on reset. All state updates on the rising edge of clk.
- Outputs are combinational from the registered state and the current inputs.
- While reset=1: all *_flush=1, all *_stall=0, pc_stall=0, pc_redirect=0, bus_error=0.
- After reset: state=RUN, discard_pending=0, to_cnt=0, counters=0.
- FSM states: RUN, DWAIT, ERR.
- Priority within RUN and DWAIT, highest first: dmem wait, redirect, load-use, imem wait.
- Dmem wait (mem_access && !dmem_ready):
  - Assert pc_stall, if_id_stall, id_ex_stall, ex_mem_stall and mem_wb_flush (bubble into WB).
  - RUN->DWAIT.
  - In DWAIT, to_cnt increments each waiting cycle. dmem_ready=1 -> RUN with to_cnt=0, and that cycle has no dmem stall.
  - to_cnt reaching DMEM_TIMEOUT-1 while still waiting -> ERR.
- Redirect (mem_branch_taken, no dmem wait):
  - Assert pc_redirect, if_id_flush, id_ex_flush and ex_mem_flush, killing the 3 younger instructions.
  - Load-use and imem-wait outputs are suppressed that cycle.
  - If imem_ready=0 that cycle, set discard_pending.
- Load-use:
  - Condition: ex_MemRead && ex_rd_addr!=0 && ((id_uses_rs1 && ex_rd_addr==id_rs1_addr) || (id_uses_rs2 && ex_rd_addr==id_rs2_addr)).
  - Response: pc_stall=1, if_id_stall=1, id_ex_flush=1. Exactly one bubble per hazard.
- Imem wait (!imem_ready): pc_stall=1 and if_id_flush=1 (NOP into ID); downstream stages advance.
- discard_pending:
  - On the first cycle with imem_ready=1 while set: if_id_flush=1, pc_stall=0, then clear the flag.
  - A new redirect in the same cycle keeps the flag set.
- ERR: all *_stall=1, all *_flush=0, bus_error=1, pc_redirect=0. Sticky until reset.
- A stall and a flush are never asserted together on the same register, except during reset.
- Simultaneous mem_branch_taken and mem_access are illegal (one MEM instruction). If both occur, dmem wins and the redirect re-presents after the wait, because EX/MEM is held.

Optional Feature:
Macro: HAZARD_PERF_EN.
- Defined:
  - stall_cycles increments on every cycle with pc_stall=1.
  - flush_events increments on every cycle with pc_redirect=1.
  - Both are 32-bit, saturate at 0xFFFFFFFF, and clear on reset.
- Undefined: both ports are tied to 0 and no counter flops are built.

Decomposition:
- FSM state encodings (RUN=2'd0, DWAIT=2'd1, ERR=2'd2) and default DMEM_TIMEOUT go as `define constants in the shared isa.v include, alongside XLEN.
- One natural sub-module, hazard_perf_cnt: the saturating counter pair, instantiated only under HAZARD_PERF_EN.

Test Plan:
- Load-use: lw x5 in EX (ex_MemRead=1, ex_rd=5), ID add with rs1=5, id_uses_rs1=1 -> one cycle of pc_stall=1, if_id_stall=1, id_ex_flush=1. ex_rd=0 -> no stall.
- Redirect: mem_branch_taken=1 for 1 cycle -> pc_redirect, if_id_flush, id_ex_flush, ex_mem_flush=1 that cycle only. Concurrent load-use outputs suppressed.
- Dmem wait: mem_access=1, dmem_ready=0 for 3 cycles then 1 -> stalls on pc..ex_mem plus mem_wb_flush for 3 cycles, state back to RUN on cycle 4.
- Timeout: DMEM_TIMEOUT=4, dmem_ready held 0 -> bus_error=1 after 4 wait cycles, all stalls=1, sticky. Synchronous reset pulse clears it.
- Stale fetch: redirect with imem_ready=0, imem_ready=1 two cycles later -> if_id_flush=1 on that cycle, then normal fetch.
- HAZARD_PERF_EN: 5 stall cycles and 2 redirects -> stall_cycles=5, flush_events=2. Without the macro both read 0.

Source files
------------

// File: rtl/hazard_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// hazard_ctrl_pkg
// Shared definitions for the pipeline hazard controller:
//   - FSM state encodings (RUN / DWAIT / ERR)
//   - default data-memory timeout
//   - the pipeline-control bundle type driven by hazard_ctrl
//   - helper functions: load-use match and 32-bit saturating increment
// -----------------------------------------------------------------------------
package hazard_ctrl_pkg;

    localparam int REG_ADDR_W       = 5;
    localparam int DMEM_TIMEOUT_DEF = 64;

    // FSM encodings kept as plain 2-bit constants for legacy compatibility.
    localparam logic [1:0] ST_RUN   = 2'd0;
    localparam logic [1:0] ST_DWAIT = 2'd1;
    localparam logic [1:0] ST_ERR   = 2'd2;

    // Stall/flush bundle for the PC and the four pipeline registers.
    typedef struct packed {
        logic pc_stall;
        logic pc_redirect;
        logic if_id_stall;
        logic if_id_flush;
        logic id_ex_stall;
        logic id_ex_flush;
        logic ex_mem_stall;
        logic ex_mem_flush;
        logic mem_wb_stall;
        logic mem_wb_flush;
    } pipe_ctl_t;

    // True when the load in EX writes a register the ID instruction reads.
    // x0 is never a real dependency.
    function automatic logic load_use_hit(
        input logic                  ex_mem_read,
        input logic [REG_ADDR_W-1:0] ex_rd,
        input logic                  uses_rs1,
        input logic [REG_ADDR_W-1:0] rs1,
        input logic                  uses_rs2,
        input logic [REG_ADDR_W-1:0] rs2
    );
        logic hit;
        hit = ex_mem_read && (ex_rd != {REG_ADDR_W{1'b0}}) &&
              ((uses_rs1 && (ex_rd == rs1)) || (uses_rs2 && (ex_rd == rs2)));
        return hit;
    endfunction

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [31:0] sat_inc32(input logic [31:0] value);
        logic [31:0] result;
        if (value == 32'hFFFF_FFFF) begin
            result = value;
        end else begin
            result = value + 32'd1;
        end
        return result;
    endfunction

endpackage

// File: rtl/hazard_perf_cnt.sv
// -----------------------------------------------------------------------------
// hazard_perf_cnt
// Saturating performance counter pair for the hazard controller. Only
// instantiated when HAZARD_PERF_EN is defined.
//
// Ports:
//   clk          in   clock, rising edge
//   reset        in   synchronous active-high reset, clears both counters
//   pc_stall     in   counts one stall cycle when high
//   pc_redirect  in   counts one flush event when high
//   stall_cycles out  saturating count of pc_stall cycles
//   flush_events out  saturating count of pc_redirect cycles
// -----------------------------------------------------------------------------
module hazard_perf_cnt
    import hazard_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        pc_stall,
    input  logic        pc_redirect,
    output logic [31:0] stall_cycles,
    output logic [31:0] flush_events
);

    logic [31:0] stall_cnt_r;
    logic [31:0] flush_cnt_r;

    // Counter registers: saturate rather than wrap.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_r <= 32'd0;
            flush_cnt_r <= 32'd0;
        end else begin
            if (pc_stall) begin
                stall_cnt_r <= sat_inc32(stall_cnt_r);
            end
            if (pc_redirect) begin
                flush_cnt_r <= sat_inc32(flush_cnt_r);
            end
        end
    end

    assign stall_cycles = stall_cnt_r;
    assign flush_events = flush_cnt_r;

endmodule

// File: rtl/hazard_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_ctrl
// Central stall/flush generator for the 5-stage pipeline. Handles, in priority
// order: data-memory wait, MEM-stage redirect, load-use hazard, instruction
// memory wait, and discarding a stale fetch that returns after a redirect.
// A data-memory wait lasting DMEM_TIMEOUT cycles locks the pipeline in ERR
// (every register stalled, bus_error high) until reset.
//
// Configuration macro: HAZARD_PERF_EN -- builds the saturating stall/flush
// performance counters; without it stall_cycles/flush_events read 0.
//
// Parameters:
//   DMEM_TIMEOUT  consecutive dmem wait cycles before bus_error (>= 2)
//   TO_W          timeout counter width (derived, do not override)
//
// Ports:
//   clk, reset                         clock / synchronous active-high reset
//   id_rs1_addr, id_rs2_addr           source registers of the ID instruction
//   id_uses_rs1, id_uses_rs2           ID instruction reads rs1 / rs2
//   ex_rd_addr, ex_MemRead             destination and load flag of EX
//   mem_branch_taken                   taken branch/jump resolved in MEM
//   mem_access                         MEM instruction is a load/store
//   dmem_ready, imem_ready             memory completion handshakes
//   pc_stall, pc_redirect              PC hold / load branch target
//   <reg>_stall, <reg>_flush           IF/ID, ID/EX, EX/MEM, MEM/WB controls
//   bus_error                          sticky data-memory timeout
//   stall_cycles, flush_events         performance counters
//
// Outputs are combinational from the registered state and current inputs.
// -----------------------------------------------------------------------------
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int DMEM_TIMEOUT = DMEM_TIMEOUT_DEF,
    parameter int TO_W         = $clog2(DMEM_TIMEOUT + 1)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [REG_ADDR_W-1:0] id_rs1_addr,
    input  logic [REG_ADDR_W-1:0] id_rs2_addr,
    input  logic                  id_uses_rs1,
    input  logic                  id_uses_rs2,
    input  logic [REG_ADDR_W-1:0] ex_rd_addr,
    input  logic                  ex_MemRead,
    input  logic                  mem_branch_taken,
    input  logic                  mem_access,
    input  logic                  dmem_ready,
    input  logic                  imem_ready,
    output logic                  pc_stall,
    output logic                  pc_redirect,
    output logic                  if_id_stall,
    output logic                  if_id_flush,
    output logic                  id_ex_stall,
    output logic                  id_ex_flush,
    output logic                  ex_mem_stall,
    output logic                  ex_mem_flush,
    output logic                  mem_wb_stall,
    output logic                  mem_wb_flush,
    output logic                  bus_error,
    output logic [31:0]           stall_cycles,
    output logic [31:0]           flush_events
);

    localparam logic [TO_W-1:0] TO_LAST = TO_W'(DMEM_TIMEOUT - 1);

    logic [1:0]      state_r;
    logic [1:0]      state_nxt_s;
    logic [TO_W-1:0] to_cnt_r;
    logic [TO_W-1:0] to_cnt_nxt_s;
    logic            discard_r;
    logic            discard_nxt_s;

    logic            dmem_wait_s;
    logic            load_use_s;
    pipe_ctl_t       ctl_s;
    logic            bus_error_s;

    // Hazard conditions decoded from the current pipeline inputs.
    always_comb begin
        dmem_wait_s = mem_access && !dmem_ready;
        load_use_s  = load_use_hit(ex_MemRead, ex_rd_addr,
                                   id_uses_rs1, id_rs1_addr,
                                   id_uses_rs2, id_rs2_addr);
    end

    // Stall/flush generation, highest priority first.
    always_comb begin
        ctl_s       = '0;
        bus_error_s = 1'b0;
        if (reset) begin
            // Flush everything while reset is held so no stale state survives.
            ctl_s.if_id_flush  = 1'b1;
            ctl_s.id_ex_flush  = 1'b1;
            ctl_s.ex_mem_flush = 1'b1;
            ctl_s.mem_wb_flush = 1'b1;
        end else begin
            case (state_r)
                ST_RUN, ST_DWAIT: begin
                    if (dmem_wait_s) begin
                        // Hold everything up to EX/MEM; WB receives a bubble.
                        // Holding EX/MEM also re-presents an illegal
                        // concurrent branch once the wait completes.
                        ctl_s.pc_stall     = 1'b1;
                        ctl_s.if_id_stall  = 1'b1;
                        ctl_s.id_ex_stall  = 1'b1;
                        ctl_s.ex_mem_stall = 1'b1;
                        ctl_s.mem_wb_flush = 1'b1;
                    end else if (mem_branch_taken) begin
                        // Kill the three younger instructions; lower-priority
                        // hazards are moot because those instructions die.
                        ctl_s.pc_redirect  = 1'b1;
                        ctl_s.if_id_flush  = 1'b1;
                        ctl_s.id_ex_flush  = 1'b1;
                        ctl_s.ex_mem_flush = 1'b1;
                    end else if (load_use_s) begin
                        // One bubble: the load leaves EX next cycle, so the
                        // condition clears by itself.
                        ctl_s.pc_stall    = 1'b1;
                        ctl_s.if_id_stall = 1'b1;
                        ctl_s.id_ex_flush = 1'b1;
                    end else if (!imem_ready) begin
                        // No instruction yet: NOP into ID, downstream drains.
                        ctl_s.pc_stall    = 1'b1;
                        ctl_s.if_id_flush = 1'b1;
                    end else if (discard_r) begin
                        // This fetch belongs to the pre-redirect path; drop it
                        // and let the PC move on from the branch target.
                        ctl_s.if_id_flush = 1'b1;
                    end else begin
                        ctl_s = '0;
                    end
                end
                default: begin
                    // ERR, or a corrupted state encoding: freeze the pipeline.
                    ctl_s.pc_stall     = 1'b1;
                    ctl_s.if_id_stall  = 1'b1;
                    ctl_s.id_ex_stall  = 1'b1;
                    ctl_s.ex_mem_stall = 1'b1;
                    ctl_s.mem_wb_stall = 1'b1;
                    bus_error_s        = 1'b1;
                end
            endcase
        end
    end

    // Next-state logic for the wait FSM, timeout counter and discard flag.
    always_comb begin
        state_nxt_s   = state_r;
        to_cnt_nxt_s  = to_cnt_r;
        discard_nxt_s = discard_r;
        case (state_r)
            ST_RUN, ST_DWAIT: begin
                if (dmem_wait_s) begin
                    if (state_r == ST_RUN) begin
                        // First waiting cycle counts as one.
                        state_nxt_s  = ST_DWAIT;
                        to_cnt_nxt_s = TO_W'(1);
                    end else if (to_cnt_r == TO_LAST) begin
                        state_nxt_s  = ST_ERR;
                    end else begin
                        to_cnt_nxt_s = to_cnt_r + TO_W'(1);
                    end
                end else begin
                    state_nxt_s  = ST_RUN;
                    to_cnt_nxt_s = '0;
                    if (mem_branch_taken) begin
                        // A fetch still in flight will return stale data.
                        discard_nxt_s = discard_r | !imem_ready;
                    end else if (load_use_s || !imem_ready) begin
                        // Stale fetch not consumed this cycle.
                        discard_nxt_s = discard_r;
                    end else begin
                        // Any pending stale fetch was flushed this cycle.
                        discard_nxt_s = 1'b0;
                    end
                end
            end
            ST_ERR: begin
                state_nxt_s = ST_ERR;
            end
            default: begin
                state_nxt_s = ST_ERR;
            end
        endcase
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r   <= ST_RUN;
            to_cnt_r  <= '0;
            discard_r <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            to_cnt_r  <= to_cnt_nxt_s;
            discard_r <= discard_nxt_s;
        end
    end

    assign pc_stall     = ctl_s.pc_stall;
    assign pc_redirect  = ctl_s.pc_redirect;
    assign if_id_stall  = ctl_s.if_id_stall;
    assign if_id_flush  = ctl_s.if_id_flush;
    assign id_ex_stall  = ctl_s.id_ex_stall;
    assign id_ex_flush  = ctl_s.id_ex_flush;
    assign ex_mem_stall = ctl_s.ex_mem_stall;
    assign ex_mem_flush = ctl_s.ex_mem_flush;
    assign mem_wb_stall = ctl_s.mem_wb_stall;
    assign mem_wb_flush = ctl_s.mem_wb_flush;
    assign bus_error    = bus_error_s;

`ifdef HAZARD_PERF_EN
    hazard_perf_cnt u_perf (
        .clk          (clk),
        .reset        (reset),
        .pc_stall     (ctl_s.pc_stall),
        .pc_redirect  (ctl_s.pc_redirect),
        .stall_cycles (stall_cycles),
        .flush_events (flush_events)
    );
`else
    assign stall_cycles = 32'd0;
    assign flush_events = 32'd0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_hazard_ctrl
// Directed scoreboard bench for hazard_ctrl (DMEM_TIMEOUT = 4). The driver
// applies one input vector per cycle and queues the hand-computed control
// vector; the monitor pops and compares at the falling edge.
// Control vector bit order (MSB..LSB):
//   pc_stall pc_redirect if_id_stall if_id_flush id_ex_stall id_ex_flush
//   ex_mem_stall ex_mem_flush mem_wb_stall mem_wb_flush bus_error
// -----------------------------------------------------------------------------
module tb_hazard_ctrl;

    localparam logic [10:0] E_NONE  = 11'b00000000000;
    localparam logic [10:0] E_RESET = 11'b00010101010;
    localparam logic [10:0] E_DMEM  = 11'b10101010010;
    localparam logic [10:0] E_REDIR = 11'b01010101000;
    localparam logic [10:0] E_LU    = 11'b10100100000;
    localparam logic [10:0] E_IMEM  = 11'b10010000000;
    localparam logic [10:0] E_DISC  = 11'b00010000000;
    localparam logic [10:0] E_ERR   = 11'b10101010101;

`ifdef HAZARD_PERF_EN
    localparam logic [31:0] EXP_SC = 32'd5;
    localparam logic [31:0] EXP_FE = 32'd2;
`else
    localparam logic [31:0] EXP_SC = 32'd0;
    localparam logic [31:0] EXP_FE = 32'd0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  id_rs1_addr, id_rs2_addr, ex_rd_addr;
    logic        id_uses_rs1, id_uses_rs2, ex_MemRead;
    logic        mem_branch_taken, mem_access, dmem_ready, imem_ready;
    logic        pc_stall, pc_redirect;
    logic        if_id_stall, if_id_flush, id_ex_stall, id_ex_flush;
    logic        ex_mem_stall, ex_mem_flush, mem_wb_stall, mem_wb_flush;
    logic        bus_error;
    logic [31:0] stall_cycles, flush_events;

    // staged inputs for the next step
    logic        s_reset, s_u1, s_u2, s_exmr, s_br, s_macc, s_dready, s_iready;
    logic [4:0]  s_rs1, s_rs2, s_exrd;

    typedef struct {
        logic [10:0] ctl;
        bit          chk_perf;
        logic [31:0] sc;
        logic [31:0] fe;
        string       name;
    } exp_t;

    exp_t sb_q[$];
    int   errors = 0;
    int   checks = 0;

    hazard_ctrl #(.DMEM_TIMEOUT(4)) dut (
        .clk              (clk),
        .reset            (reset),
        .id_rs1_addr      (id_rs1_addr),
        .id_rs2_addr      (id_rs2_addr),
        .id_uses_rs1      (id_uses_rs1),
        .id_uses_rs2      (id_uses_rs2),
        .ex_rd_addr       (ex_rd_addr),
        .ex_MemRead       (ex_MemRead),
        .mem_branch_taken (mem_branch_taken),
        .mem_access       (mem_access),
        .dmem_ready       (dmem_ready),
        .imem_ready       (imem_ready),
        .pc_stall         (pc_stall),
        .pc_redirect      (pc_redirect),
        .if_id_stall      (if_id_stall),
        .if_id_flush      (if_id_flush),
        .id_ex_stall      (id_ex_stall),
        .id_ex_flush      (id_ex_flush),
        .ex_mem_stall     (ex_mem_stall),
        .ex_mem_flush     (ex_mem_flush),
        .mem_wb_stall     (mem_wb_stall),
        .mem_wb_flush     (mem_wb_flush),
        .bus_error        (bus_error),
        .stall_cycles     (stall_cycles),
        .flush_events     (flush_events)
    );

    always #5 clk = ~clk;

    task automatic clear_stage();
        s_reset = 1'b0; s_u1 = 1'b0; s_u2 = 1'b0; s_exmr = 1'b0;
        s_br = 1'b0; s_macc = 1'b0; s_dready = 1'b1; s_iready = 1'b1;
        s_rs1 = 5'd0; s_rs2 = 5'd0; s_exrd = 5'd0;
    endtask

    task automatic step_perf(input logic [10:0] exp_ctl, input bit cp,
                             input logic [31:0] sc, input logic [31:0] fe,
                             input string nm);
        exp_t e;
        @(posedge clk);
        #1;
        reset = s_reset; id_rs1_addr = s_rs1; id_rs2_addr = s_rs2;
        id_uses_rs1 = s_u1; id_uses_rs2 = s_u2; ex_rd_addr = s_exrd;
        ex_MemRead = s_exmr; mem_branch_taken = s_br; mem_access = s_macc;
        dmem_ready = s_dready; imem_ready = s_iready;
        e.ctl = exp_ctl; e.chk_perf = cp; e.sc = sc; e.fe = fe; e.name = nm;
        sb_q.push_back(e);
        clear_stage();
    endtask

    task automatic step(input logic [10:0] exp_ctl, input string nm);
        step_perf(exp_ctl, 1'b0, 32'd0, 32'd0, nm);
    endtask

    // monitor: compare DUT outputs against the queued expectation
    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            exp_t e;
            logic [10:0] act;
            e = sb_q.pop_front();
            act = {pc_stall, pc_redirect, if_id_stall, if_id_flush,
                   id_ex_stall, id_ex_flush, ex_mem_stall, ex_mem_flush,
                   mem_wb_stall, mem_wb_flush, bus_error};
            checks++;
            if (act !== e.ctl) begin
                errors++;
                $display("FAIL %s: ctl got %b expected %b", e.name, act, e.ctl);
            end
            if (e.chk_perf) begin
                checks++;
                if (stall_cycles !== e.sc) begin
                    errors++;
                    $display("FAIL %s_stall_cycles: got %0d expected %0d",
                             e.name, stall_cycles, e.sc);
                end
                checks++;
                if (flush_events !== e.fe) begin
                    errors++;
                    $display("FAIL %s_flush_events: got %0d expected %0d",
                             e.name, flush_events, e.fe);
                end
            end
        end
    end

    initial begin
        clear_stage();
        reset = 1'b1; id_rs1_addr = 5'd0; id_rs2_addr = 5'd0;
        id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0; ex_rd_addr = 5'd0;
        ex_MemRead = 1'b0; mem_branch_taken = 1'b0; mem_access = 1'b0;
        dmem_ready = 1'b1; imem_ready = 1'b1;

        // reset
        s_reset = 1'b1; step(E_RESET, "reset0");
        s_reset = 1'b1; step_perf(E_RESET, 1'b1, 32'd0, 32'd0, "reset1");
        step(E_NONE, "idle");

        // load-use
        s_exmr = 1'b1; s_exrd = 5'd5; s_rs1 = 5'd5; s_u1 = 1'b1;
        step(E_LU, "lu_rs1");
        step(E_NONE, "lu_bubble_done");
        s_exmr = 1'b1; s_exrd = 5'd7; s_rs2 = 5'd7; s_u2 = 1'b1;
        step(E_LU, "lu_rs2");
        s_exmr = 1'b1; s_exrd = 5'd0; s_rs1 = 5'd0; s_u1 = 1'b1;
        step(E_NONE, "lu_x0");
        s_exmr = 1'b1; s_exrd = 5'd5; s_rs1 = 5'd5; s_rs2 = 5'd5;
        step(E_NONE, "lu_unused");

        // redirect with a concurrent load-use
        s_br = 1'b1; s_exmr = 1'b1; s_exrd = 5'd5; s_rs1 = 5'd5; s_u1 = 1'b1;
        step(E_REDIR, "redir_lu");
        step(E_NONE, "redir_once");

        // dmem wait, 3 cycles then ready
        for (int i = 0; i < 3; i++) begin
            s_macc = 1'b1; s_dready = 1'b0; step(E_DMEM, "dwait");
        end
        s_macc = 1'b1; step(E_NONE, "dwait_done");

        // dmem wait beats a concurrent branch; branch re-presents afterwards
        s_macc = 1'b1; s_dready = 1'b0; s_br = 1'b1; step(E_DMEM, "dwait_br");
        for (int i = 0; i < 2; i++) begin
            s_macc = 1'b1; s_dready = 1'b0; s_br = 1'b1; step(E_DMEM, "dwait_br_hold");
        end
        s_br = 1'b1; step(E_REDIR, "br_after_wait");

        // stale fetch discard
        s_br = 1'b1; s_iready = 1'b0; step(E_REDIR, "stale_redir");
        s_iready = 1'b0; step(E_IMEM, "stale_wait");
        step(E_DISC, "stale_drop");
        step(E_NONE, "stale_after");

        // a redirect with imem ready keeps a pending discard
        s_br = 1'b1; s_iready = 1'b0; step(E_REDIR, "keep_redir1");
        s_br = 1'b1; step(E_REDIR, "keep_redir2");
        step(E_DISC, "keep_drop");
        step(E_NONE, "keep_after");

        // plain imem wait
        s_iready = 1'b0; step(E_IMEM, "imem_wait");
        step(E_NONE, "imem_done");

        // perf counters: 5 stall cycles, 2 redirects
        s_reset = 1'b1; step(E_RESET, "perf_reset");
        step_perf(E_NONE, 1'b1, 32'd0, 32'd0, "perf_clear");
        for (int i = 0; i < 5; i++) begin
            s_iready = 1'b0; step(E_IMEM, "perf_stall");
        end
        for (int i = 0; i < 2; i++) begin
            s_br = 1'b1; step(E_REDIR, "perf_redir");
        end
        step_perf(E_NONE, 1'b1, EXP_SC, EXP_FE, "perf_count");

        // dmem timeout after 4 wait cycles, sticky until reset
        for (int i = 0; i < 4; i++) begin
            s_macc = 1'b1; s_dready = 1'b0; step(E_DMEM, "to_wait");
        end
        s_macc = 1'b1; s_dready = 1'b0; step(E_ERR, "to_err");
        step(E_ERR, "to_sticky");
        s_br = 1'b1; step(E_ERR, "to_no_redirect");
        s_reset = 1'b1; step(E_RESET, "to_reset");
        step_perf(E_NONE, 1'b1, 32'd0, 32'd0, "to_cleared");

        // drain the scoreboard with a bounded wait
        for (int i = 0; i < 10 && sb_q.size() != 0; i++) begin
            @(negedge clk);
            #1;
        end
        if (sb_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d entries left, expected 0", sb_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
